// File: rtl/cpu_alu_seq_if.sv
// Shared ALU types and the control-decoder <-> ALU handshake bundle.
//   cpu_pkg         : alu_control_type encoding and {N,V,Z,C} flag bit indices.
//   cpu_alu_seq_if  : start/ctl/bit8/bcd/a/b/c_in requests (master -> slave),
//                     busy/done/y/flags responses (slave -> master).
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_OR  = 4'd0,
    ALU_AND = 4'd1,
    ALU_EOR = 4'd2,
    ALU_BIT = 4'd3,
    ALU_ADD = 4'd4,
    ALU_ADC = 4'd5,
    ALU_SUB = 4'd6,
    ALU_SBC = 4'd7,
    ALU_TSB = 4'd8,
    ALU_TRB = 4'd9,
    ALU_ASL = 4'd10,
    ALU_LSR = 4'd11,
    ALU_ROL = 4'd12,
    ALU_ROR = 4'd13
  } alu_control_type;

  // Bit positions inside the 4-bit {N,V,Z,C} flag vector
  localparam int unsigned AN = 3;
  localparam int unsigned AV = 2;
  localparam int unsigned AZ = 1;
  localparam int unsigned AC = 0;

endpackage

interface cpu_alu_seq_if #(
  parameter int unsigned DATA_W = 16
);
  logic                      start;
  cpu_pkg::alu_control_type  ctl;
  logic                      bit8;
  logic                      bcd;
  logic [DATA_W-1:0]         a;
  logic [DATA_W-1:0]         b;
  logic                      c_in;
  logic                      busy;
  logic                      done;
  logic [DATA_W-1:0]         y;
  logic [3:0]                flags;

  modport master (
    output start, ctl, bit8, bcd, a, b, c_in,
    input  busy, done, y, flags
  );

  modport slave (
    input  start, ctl, bit8, bcd, a, b, c_in,
    output busy, done, y, flags
  );
endinterface

// File: rtl/cpu_alu_seq.sv
// cpu_alu_seq: multi-cycle 65816 ALU, DATA_W-bit datapath (multiple of 8, >= 16).
// Binary ops complete with latency 1; decimal ADC/SBC runs one nibble per cycle,
// nibble 0 being done in the accept cycle so latency equals the nibble count.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : cpu_alu_seq_if.slave (start/ctl/bit8/bcd/a/b/c_in in, busy/done/y/flags out)
// Build option: define CPU_ALU_BCD_EN to build the decimal path; otherwise bcd is ignored.
module cpu_alu_seq #(
  parameter int unsigned DATA_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  cpu_alu_seq_if.slave   bus
);
  import cpu_pkg::*;

  localparam int unsigned SUM_W   = DATA_W + 1;
  localparam int unsigned NIB_MAX = DATA_W / 4;
  localparam int unsigned NIB_W   = $clog2(NIB_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIN  = 2'd1
`ifdef CPU_ALU_BCD_EN
    ,
    ST_BCD  = 2'd2
`endif
  } state_t;

  state_t state_q, state_d;

  logic              busy_q, done_q, busy_d, done_d;
  logic [DATA_W-1:0] y_q;
  logic [3:0]        flags_q;
  logic              load_bin;
  logic              go_bcd;

  // {N,Z} of a result at the effective width
  function automatic logic [1:0] nz_of(input logic [DATA_W-1:0] v, input logic w8);
    logic n, z;
    n = w8 ? v[7] : v[DATA_W-1];
    z = w8 ? (v[7:0] == 8'h00) : (v == '0);
    return {n, z};
  endfunction

  // Binary datapath, evaluated on the live request in the accept cycle
  logic [DATA_W-1:0] bop, r, bin_y, and_ab;
  logic [SUM_W-1:0]  sum_f;
  logic [8:0]        sum_8;
  logic [3:0]        bin_f;
  logic [1:0]        bin_nz;
  logic              cin, sub, arith, c_o, a_m, b_m, r_m, w8, zab;

  always_comb begin
    w8    = bus.bit8;
    r     = bus.a;
    cin   = 1'b0;
    sub   = 1'b0;
    arith = 1'b0;
    c_o   = 1'b0;
    case (bus.ctl)
      ALU_OR:  r = bus.a | bus.b;
      ALU_AND: r = bus.a & bus.b;
      ALU_EOR: r = bus.a ^ bus.b;
      ALU_BIT: r = bus.a;
      ALU_ADD: arith = 1'b1;
      ALU_ADC: begin arith = 1'b1; cin = bus.c_in; end
      ALU_SUB: begin arith = 1'b1; sub = 1'b1; cin = 1'b1; end
      ALU_SBC: begin arith = 1'b1; sub = 1'b1; cin = bus.c_in; end
      ALU_TSB: r = bus.b | bus.a;
      ALU_TRB: r = bus.b & ~bus.a;
      ALU_ASL: begin
        r   = w8 ? {bus.a[DATA_W-1:8], bus.a[6:0], 1'b0} : {bus.a[DATA_W-2:0], 1'b0};
        c_o = w8 ? bus.a[7] : bus.a[DATA_W-1];
      end
      ALU_LSR: begin
        r   = w8 ? {bus.a[DATA_W-1:8], 1'b0, bus.a[7:1]} : {1'b0, bus.a[DATA_W-1:1]};
        c_o = bus.a[0];
      end
      ALU_ROL: begin
        r   = w8 ? {bus.a[DATA_W-1:8], bus.a[6:0], bus.c_in} : {bus.a[DATA_W-2:0], bus.c_in};
        c_o = w8 ? bus.a[7] : bus.a[DATA_W-1];
      end
      ALU_ROR: begin
        r   = w8 ? {bus.a[DATA_W-1:8], bus.c_in, bus.a[7:1]} : {bus.c_in, bus.a[DATA_W-1:1]};
        c_o = bus.a[0];
      end
      default: r = bus.a;
    endcase

    bop   = sub ? ~bus.b : bus.b;
    sum_f = {1'b0, bus.a} + {1'b0, bop} + SUM_W'(cin);
    sum_8 = {1'b0, bus.a[7:0]} + {1'b0, bop[7:0]} + 9'(cin);
    if (arith) begin
      r   = w8 ? {bus.a[DATA_W-1:8], sum_8[7:0]} : sum_f[DATA_W-1:0];
      c_o = w8 ? sum_8[8] : sum_f[DATA_W];
    end

    // Upper bits always carry a through in 8-bit mode
    bin_y  = w8 ? {bus.a[DATA_W-1:8], r[7:0]} : r;
    bin_nz = nz_of(bin_y, w8);
    and_ab = bus.a & bus.b;
    zab    = w8 ? (and_ab[7:0] == 8'h00) : (and_ab == '0);
    a_m    = w8 ? bus.a[7] : bus.a[DATA_W-1];
    b_m    = w8 ? bop[7]   : bop[DATA_W-1];
    r_m    = w8 ? r[7]     : r[DATA_W-1];

    bin_f = 4'b0000;
    case (bus.ctl)
      ALU_BIT: begin
        bin_f[AN] = w8 ? bus.b[7] : bus.b[DATA_W-1];
        bin_f[AV] = w8 ? bus.b[6] : bus.b[DATA_W-2];
        bin_f[AZ] = zab;
      end
      ALU_TSB, ALU_TRB: bin_f[AZ] = zab;
      default: begin
        bin_f[AN] = bin_nz[1];
        bin_f[AZ] = bin_nz[0];
        bin_f[AC] = c_o;
        bin_f[AV] = arith & (a_m == b_m) & (r_m != a_m);
      end
    endcase
  end

`ifdef CPU_ALU_BCD_EN
  // Decimal nibble engine; operands come from the bus in IDLE, from the latches after
  logic [DATA_W-1:0] acc_q, b_q, d_acc, d_b, acc_d;
  logic [NIB_W-1:0]  nib_q, d_idx;
  logic              carry_q, sbc_q, bit8_q, d_c, d_sbc, d_bit8;
  logic [3:0]        an, bo, nib;
  logic [4:0]        s;
  logic              dec_c, dec_v, dec_last, dec_step;
  logic [3:0]        dec_f;
  logic [1:0]        dec_nz;

  assign go_bcd = bus.bcd & ((bus.ctl == ALU_ADC) | (bus.ctl == ALU_SBC));

  always_comb begin
    if (state_q == ST_IDLE) begin
      d_acc  = bus.a;
      d_b    = bus.b;
      d_c    = bus.c_in;
      d_sbc  = (bus.ctl == ALU_SBC);
      d_bit8 = bus.bit8;
      d_idx  = '0;
    end else begin
      d_acc  = acc_q;
      d_b    = b_q;
      d_c    = carry_q;
      d_sbc  = sbc_q;
      d_bit8 = bit8_q;
      d_idx  = nib_q;
    end
    an = d_acc[{d_idx, 2'b00} +: 4];
    bo = d_sbc ? ~d_b[{d_idx, 2'b00} +: 4] : d_b[{d_idx, 2'b00} +: 4];
    s  = {1'b0, an} + {1'b0, bo} + 5'(d_c);
    if (d_sbc) begin
      // Borrow (no carry out of the nibble) takes 6 off
      dec_c = s[4];
      nib   = dec_c ? s[3:0] : s[3:0] - 4'd6;
    end else begin
      dec_c = (s > 5'd9);
      nib   = dec_c ? s[3:0] + 4'd6 : s[3:0];
    end
    // Overflow from the unadjusted nibble sum; only the top nibble's value is kept
    dec_v = (an[3] == bo[3]) & (s[3] != an[3]);
    acc_d = d_acc;
    acc_d[{d_idx, 2'b00} +: 4] = nib;
    dec_last = (d_idx == (d_bit8 ? NIB_W'(1) : NIB_W'(NIB_MAX - 1)));
    dec_nz   = nz_of(acc_d, d_bit8);
    dec_f    = 4'b0000;
    dec_f[AN] = dec_nz[1];
    dec_f[AV] = dec_v;
    dec_f[AZ] = dec_nz[0];
    dec_f[AC] = dec_c;
  end
`else
  logic unused_bcd;
  assign unused_bcd = bus.bcd;
  assign go_bcd     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d = ST_BIN;
`ifdef CPU_ALU_BCD_EN
        if (go_bcd) state_d = ST_BCD;
`endif
      end
      // BIN is also the completion cycle of a decimal op
      ST_BIN: state_d = ST_IDLE;
`ifdef CPU_ALU_BCD_EN
      ST_BCD: if (dec_last) state_d = ST_BIN;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, registered below
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load_bin = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_BIN);
    load_bin = (state_q == ST_IDLE) & bus.start & ~go_bcd;
`ifdef CPU_ALU_BCD_EN
    dec_step = 1'b0;
    dec_step = ((state_q == ST_IDLE) & bus.start & go_bcd) | (state_q == ST_BCD);
`endif
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      flags_q <= 4'b0000;
`ifdef CPU_ALU_BCD_EN
      acc_q   <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sbc_q   <= 1'b0;
      bit8_q  <= 1'b0;
      nib_q   <= '0;
`endif
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (load_bin) begin
        y_q     <= bin_y;
        flags_q <= bin_f;
      end
`ifdef CPU_ALU_BCD_EN
      if (dec_step) begin
        acc_q   <= acc_d;
        carry_q <= dec_c;
        nib_q   <= d_idx + NIB_W'(1);
        if (state_q == ST_IDLE) begin
          b_q    <= bus.b;
          sbc_q  <= d_sbc;
          bit8_q <= bus.bit8;
        end
        if ((state_q == ST_BCD) && dec_last) begin
          y_q     <= acc_d;
          flags_q <= dec_f;
          nib_q   <= '0;
        end
      end
`endif
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.y     = y_q;
  assign bus.flags = flags_q;

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Directed testbench for cpu_alu_seq (DATA_W=16); expectations follow CPU_ALU_BCD_EN.
module tb_cpu_alu_seq;
  import cpu_pkg::*;

`ifdef CPU_ALU_BCD_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif
  localparam int LAT_MAX = 20;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  cpu_alu_seq_if #(.DATA_W(16)) bus ();

  cpu_alu_seq #(.DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input alu_control_type ctl, input logic w8, input logic dec,
                       input logic [15:0] a, input logic [15:0] b, input logic ci);
    bus.ctl  = ctl;
    bus.bit8 = w8;
    bus.bcd  = dec;
    bus.a    = a;
    bus.b    = b;
    bus.c_in = ci;
  endtask

  // Issue one op, measure start-to-done latency and busy span, check results
  task automatic run_op(input string tag, input alu_control_type ctl, input logic w8,
                        input logic dec, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input int exp_lat, input logic [15:0] exp_y,
                        input logic [3:0] exp_f);
    int lat;
    int busy_n;
    @(negedge clk);
    drive(ctl, w8, dec, a, b, ci);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!bus.done && lat < LAT_MAX) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy) busy_n++;
    check({tag, "_lat"},   32'(lat),       32'(exp_lat));
    check({tag, "_busy"},  32'(busy_n),    32'(exp_lat));
    check({tag, "_y"},     32'(bus.y),     32'(exp_y));
    check({tag, "_flags"}, 32'(bus.flags), 32'(exp_f));
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'({bus.busy, bus.done}), 32'(0));
  endtask

  initial begin
    int  lat;
    bit  saw_done;
    reset     = 1'b1;
    bus.start = 1'b0;
    drive(ALU_OR, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_done", 32'({bus.busy, bus.done}), 32'(0));
    check("rst_y",         32'(bus.y),                32'(0));
    check("rst_flags",     32'(bus.flags),            32'(0));
    reset = 1'b0;

    // flags are {N,V,Z,C}
    run_op("adc_ovf", ALU_ADC, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 4'b1100);
    run_op("adc_bcd8", ALU_ADC, 1'b1, 1'b1, 16'h1258, 16'h0046, 1'b1,
           BCD_ON ? 2 : 1, BCD_ON ? 16'h1205 : 16'h129F, BCD_ON ? 4'b0101 : 4'b1100);
    run_op("sbc_bcd16", ALU_SBC, 1'b0, 1'b1, 16'h1000, 16'h0001, 1'b1,
           BCD_ON ? 4 : 1, BCD_ON ? 16'h0999 : 16'h0FFF, 4'b0001);
    run_op("adc_bcd_9p1", ALU_ADC, 1'b1, 1'b1, 16'h0009, 16'h0001, 1'b0,
           BCD_ON ? 2 : 1, BCD_ON ? 16'h0010 : 16'h000A, 4'b0000);
    run_op("ror8",   ALU_ROR, 1'b1, 1'b0, 16'hAB01, 16'h0000, 1'b1, 1, 16'hAB80, 4'b1001);
    run_op("bit16",  ALU_BIT, 1'b0, 1'b0, 16'h00FF, 16'hC000, 1'b0, 1, 16'h00FF, 4'b1110);
    run_op("and_z",  ALU_AND, 1'b0, 1'b0, 16'hF0F0, 16'h0F0F, 1'b0, 1, 16'h0000, 4'b0010);
    run_op("eor8",   ALU_EOR, 1'b1, 1'b0, 16'h12FF, 16'h0080, 1'b0, 1, 16'h127F, 4'b0000);
    run_op("sub_brw", ALU_SUB, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1, 16'hFFFF, 4'b1000);
    run_op("asl16",  ALU_ASL, 1'b0, 1'b0, 16'h8001, 16'h0000, 1'b0, 1, 16'h0002, 4'b0001);
    run_op("tsb",    ALU_TSB, 1'b0, 1'b0, 16'h0F00, 16'h00F0, 1'b0, 1, 16'h0FF0, 4'b0010);
    run_op("trb",    ALU_TRB, 1'b0, 1'b0, 16'h0030, 16'h00F0, 1'b0, 1, 16'h00C0, 4'b0000);
    run_op("add8_c", ALU_ADD, 1'b1, 1'b0, 16'h55FF, 16'h0001, 1'b0, 1, 16'h5500, 4'b0011);
    run_op("or_bcd", ALU_OR,  1'b0, 1'b1, 16'h1200, 16'h0034, 1'b0, 1, 16'h1234, 4'b0000);
    run_op("lsr8",   ALU_LSR, 1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0, 1, 16'hFF01, 4'b0001);
    run_op("rol16",  ALU_ROL, 1'b0, 1'b0, 16'h4000, 16'h0000, 1'b1, 1, 16'h8001, 4'b1000);

    // start held high with changing operands during an op: only the first is taken
    @(negedge clk);
    drive(ALU_SBC, 1'b0, 1'b1, 16'h1000, 16'h0001, 1'b1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (lat < LAT_MAX) begin
      if (bus.done) begin
        bus.start = 1'b0;
        break;
      end
      bus.a = 16'h5555 ^ 16'(lat);
      bus.b = 16'h0123;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check("hold_lat", 32'(lat),   32'(BCD_ON ? 4 : 1));
    check("hold_y",   32'(bus.y), 32'(BCD_ON ? 16'h0999 : 16'h0FFF));
    @(posedge clk); #1;
    check("hold_noq", 32'({bus.busy, bus.done}), 32'(0));

    // reset while nibble 1 is in flight
    @(negedge clk);
    drive(ALU_SBC, 1'b0, 1'b1, 16'h1000, 16'h0001, 1'b1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_done", 32'({bus.busy, bus.done}), 32'(0));
    check("abort_y",         32'(bus.y),                32'(0));
    check("abort_flags",     32'(bus.flags),            32'(0));
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
